// File: rtl/sc_pkg.sv
// ============================================================================
//  Module      : sc_pkg
//  Description : Shared types, default sizes and the saturating step helper
//                for the stochastic up/down accumulator bank.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef DIM
`define DIM 4
`endif
`ifndef NUM_BIT
`define NUM_BIT 8
`endif

package sc_pkg;

   localparam int SC_NUM_CH = `DIM;
   localparam int SC_ACC_W  = `NUM_BIT;
   localparam int SC_LEN_W  = 8;
   // Working width of sat_step; lane widths must stay below this.
   localparam int SC_STEP_W = 32;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_ACC       = 2'd1,
      ST_DONE      = 2'd2,
      ST_DONE_HOLD = 2'd3
   } sc_state_e;

   typedef struct packed {
      logic signed [SC_STEP_W-1:0] value;
      logic                        ovf;
   } sc_step_t;

   // One +1/-1 step on a sign-extended acc_w-bit value. The overflow flag is
   // raised whenever the step would leave the signed range, whether the
   // result is clamped (sat_en=1) or wrapped (sat_en=0).
   function automatic sc_step_t sat_step(
      input logic signed [SC_STEP_W-1:0] value,
      input logic                        dir,
      input logic                        en,
      input logic                        sat_en,
      input int                          acc_w
   );
      sc_step_t                    res;
      logic signed [SC_STEP_W-1:0] lim_max;
      logic signed [SC_STEP_W-1:0] lim_min;
      lim_max   = (32'sd1 <<< (acc_w - 1)) - 32'sd1;
      lim_min   = -(32'sd1 <<< (acc_w - 1));
      res.value = value;
      res.ovf   = 1'b0;
      if (en) begin
         if (dir) begin
            if (value == lim_max) begin
               res.ovf   = 1'b1;
               res.value = sat_en ? lim_max : lim_min;
            end else begin
               res.value = value + 32'sd1;
            end
         end else begin
            if (value == lim_min) begin
               res.ovf   = 1'b1;
               res.value = sat_en ? lim_min : lim_max;
            end else begin
               res.value = value - 32'sd1;
            end
         end
      end
      return res;
   endfunction

endpackage

`default_nettype wire

// File: rtl/sc_acc_lane.sv
// ============================================================================
//  Module      : sc_acc_lane
//  Description : Single-channel signed up/down accumulator with synchronous
//                clear and a sticky overflow/saturation flag.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sc_acc_lane
   import sc_pkg::*;
#(
   parameter int ACC_W  = 8,
   parameter bit SAT_EN = 1'b1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clr_i,
   input  logic             en_i,
   input  logic             up_i,
   output logic [ACC_W-1:0] acc_o,
   output logic             sat_o
);

   logic [ACC_W-1:0]       acc_q, acc_d;
   logic                   sat_q, sat_d;
   logic signed [SC_STEP_W-1:0] acc_ext;
   sc_step_t               step;
   logic                   unused_hi;

   assign acc_ext   = SC_STEP_W'(signed'(acc_q));
   assign step      = sat_step(acc_ext, up_i, en_i, SAT_EN, ACC_W);
   // Upper bits of the step result are only the sign extension.
   assign unused_hi = ^step.value[SC_STEP_W-1:ACC_W];

   // Next value: clear wins over stepping; the flag only ever sets until clear.
   always_comb begin
      acc_d = acc_q;
      sat_d = sat_q;
      if (clr_i) begin
         acc_d = '0;
         sat_d = 1'b0;
      end else if (en_i) begin
         acc_d = step.value[ACC_W-1:0];
         sat_d = sat_q | step.ovf;
      end
   end

   // Accumulator and sticky flag registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         acc_q <= '0;
         sat_q <= 1'b0;
      end else begin
         acc_q <= acc_d;
         sat_q <= sat_d;
      end
   end

   assign acc_o = acc_q;
   assign sat_o = sat_q;

endmodule

`default_nettype wire

// File: rtl/sc_updown_acc_bank.sv
// ============================================================================
//  Module      : sc_updown_acc_bank
//  Description : Bank of NUM_CH stochastic-bitstream accumulators with
//                programmable stream length, per-channel weight sign,
//                unipolar/bipolar mode and a start/done handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sc_updown_acc_bank
   import sc_pkg::*;
#(
   parameter int NUM_CH = SC_NUM_CH,
   parameter int ACC_W  = SC_ACC_W,
   parameter int LEN_W  = SC_LEN_W,
   parameter bit SAT_EN = 1'b1
) (
   input  logic                    i_clk_udc,
   input  logic                    i_rst_udc,
   input  logic                    i_start,
   input  logic [LEN_W-1:0]        i_len,
   input  logic                    i_bipolar,
   input  logic [NUM_CH-1:0]       i_sign_w,
   input  logic                    i_abort,
   input  logic                    i_sn_valid,
   input  logic [NUM_CH-1:0]       i_sn_bit,
   output logic                    o_ready,
   output logic                    o_busy,
   output logic                    o_done,
   output logic                    o_res_valid,
   output logic [NUM_CH*ACC_W-1:0] o_result,
   output logic [NUM_CH-1:0]       o_sat
);

   sc_state_e          state_q, state_d;
   logic [LEN_W-1:0]   cnt_q, cnt_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic               bip_q, bip_d;
   logic [NUM_CH-1:0]  sign_q, sign_d;
   logic               done_q, done_d;
   logic               rv_q, rv_d;

   logic               start_acc;
   logic               step;
   logic               last_bit;
   logic [NUM_CH-1:0]  lane_en;
   logic [NUM_CH-1:0]  lane_up;

   assign o_ready   = (state_q == ST_IDLE) || (state_q == ST_DONE_HOLD);
   assign o_busy    = (state_q == ST_ACC);
   assign start_acc = i_start && o_ready;
   // A bit landing in the abort cycle is dropped so the partial result is
   // exactly what was accumulated before the abort.
   assign step      = (state_q == ST_ACC) && i_sn_valid && !i_abort;
   assign last_bit  = step && (({1'b0, cnt_q} + 1'b1) == {1'b0, len_q});

   // Next-state, bit counter, latched run settings and result handshake.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      len_d   = len_q;
      bip_d   = bip_q;
      sign_d  = sign_q;
      rv_d    = rv_q;
      done_d  = 1'b0;
      case (state_q)
         ST_IDLE, ST_DONE_HOLD: begin
            if (start_acc) begin
               len_d   = i_len;
               bip_d   = i_bipolar;
               sign_d  = i_sign_w;
               cnt_d   = '0;
               rv_d    = 1'b0;
               state_d = (i_len == '0) ? ST_DONE : ST_ACC;
            end
         end
         ST_ACC: begin
            if (i_abort) begin
               state_d = ST_IDLE;
               rv_d    = 1'b0;
            end else if (step) begin
               cnt_d = cnt_q + 1'b1;
               if (last_bit) begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            if (i_abort) begin
               state_d = ST_IDLE;
               rv_d    = 1'b0;
            end else begin
               state_d = ST_DONE_HOLD;
               done_d  = 1'b1;
               rv_d    = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Control registers.
   always_ff @(posedge i_clk_udc or posedge i_rst_udc) begin
      if (i_rst_udc) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         len_q   <= '0;
         bip_q   <= 1'b0;
         sign_q  <= '0;
         done_q  <= 1'b0;
         rv_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         len_q   <= len_d;
         bip_q   <= bip_d;
         sign_q  <= sign_d;
         done_q  <= done_d;
         rv_q    <= rv_d;
      end
   end

   // Per-lane step controls: effective bit is the stream bit XOR weight sign;
   // unipolar mode only counts up on a 1 and otherwise holds.
   always_comb begin
      lane_en = '0;
      lane_up = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         lane_up[c] = i_sn_bit[c] ^ sign_q[c];
         lane_en[c] = step && (bip_q || lane_up[c]);
      end
   end

   generate
      for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
         sc_acc_lane #(
            .ACC_W  (ACC_W),
            .SAT_EN (SAT_EN)
         ) u_lane (
            .clk_i (i_clk_udc),
            .rst_i (i_rst_udc),
            .clr_i (start_acc),
            .en_i  (lane_en[g]),
            .up_i  (lane_up[g]),
            .acc_o (o_result[g*ACC_W +: ACC_W]),
            .sat_o (o_sat[g])
         );
      end
   endgenerate

   assign o_done      = done_q;
   assign o_res_valid = rv_q;

endmodule

`default_nettype wire

// File: doc/sc_updown_acc_bank.md
Name: sc_updown_acc_bank

Overview:
- Parametrised bank of NUM_CH stochastic-bitstream accumulators: the next-generation replacement for the per-lane up/down counter inside the MVM path.
- Adds:
  - a programmable stream length with a built-in bit counter;
  - per-channel weight sign;
  - a unipolar/bipolar mode;
  - saturating arithmetic with sticky overflow flags;
  - a start/valid/done handshake.
- Sits between the stochastic-number generator (FSM_MUX output) and the downstream result register/activation stage.

Parameters:
- NUM_CH, 4, number of parallel channels (matches `DIM).
- ACC_W, 8, accumulator width, two's complement signed.
- LEN_W, 8, width of the stream-length field.
- SAT_EN, 1, 1 = saturate at signed limits; 0 = wrap modulo 2^ACC_W.

Ports:
- i_clk_udc  in  1  clock, rising edge.
- i_rst_udc  in  1  asynchronous, active-high reset.
- i_start  in  1  start pulse; accepted only when o_ready=1.
- i_len  in  LEN_W  number of stream bits to accumulate; sampled on an accepted start.
- i_bipolar  in  1  1 = up/down per bit; 0 = up-or-hold; sampled on an accepted start.
- i_sign_w  in  NUM_CH  per-channel weight sign; sampled on an accepted start.
- i_abort  in  1  synchronous abort of a running accumulation.
- i_sn_valid  in  1  qualifies i_sn_bit this cycle.
- i_sn_bit  in  NUM_CH  one stochastic bit per channel.
- o_ready  out  1  block is in IDLE or DONE_HOLD and will accept i_start.
- o_busy  out  1  block is in ACC.
- o_done  out  1  single-cycle pulse when accumulation completes.
- o_res_valid  out  1  o_result is final; held until the next accepted start or abort.
- o_result  out  NUM_CH x ACC_W  per-channel accumulator value, signed.
- o_sat  out  NUM_CH  sticky per-channel saturation/overflow flag.

Behaviour:
- Reset (asynchronous, any state):
  - state=IDLE; all accumulators=0, bit counter=0, latched len/mode/signs=0.
  - o_ready=1, o_busy=0, o_done=0, o_res_valid=0, o_sat=0, o_result=0.
- States: IDLE, ACC, DONE, DONE_HOLD.
- Accepted start (IDLE or DONE_HOLD, i_start=1):
  - latch i_len, i_bipolar, i_sign_w; clear accumulators, o_sat and the bit counter; o_res_valid<=0.
  - Next state is ACC, or DONE if i_len==0.
- i_start while in ACC or DONE: ignored, no side effects.
- ACC, cycle with i_sn_valid=1, each channel c, with e = i_sn_bit[c] XOR sign[c]:
  - bipolar: e=1 adds +1, e=0 adds -1.
  - unipolar: e=1 adds +1, e=0 holds.
  - bit counter increments.
- ACC, cycle with i_sn_valid=0: everything holds.
- ACC exit: the accepted bit that brings the bit counter to len moves the FSM to DONE on the same edge.
- DONE: lasts exactly 1 cycle; o_done=1, o_res_valid=1; then DONE_HOLD.
- DONE_HOLD: o_res_valid=1, o_ready=1, o_result stable.
- Latency: with continuous valid, start accepted at edge 0 and len=N gives o_done high in the cycle after edge N+1. The bits are sampled at edges 1..N.
- Saturation (SAT_EN=1): +1 at +(2^(ACC_W-1)-1) holds the value; -1 at -2^(ACC_W-1) holds the value. Either case sets o_sat[c], which stays set until the next accepted start.
- Wrap (SAT_EN=0): modulo arithmetic; o_sat[c] still flags the signed overflow.
- i_abort in ACC or DONE:
  - next state IDLE; o_res_valid=0, no o_done.
  - accumulators and o_sat hold their partial values for debug.
- Abort priority: i_abort beats the completion edge.
- i_abort in IDLE or DONE_HOLD: no effect.
- Simultaneous i_start and i_abort in DONE_HOLD: the start wins.
- len = 2^LEN_W - 1: supported; the bit counter is LEN_W wide and never wraps inside a run.
- All outputs are registered except o_ready and o_busy, which are state decodes.

Decomposition:
- Shared package sc_pkg:
  - state enum type for the FSM.
  - default localparams SC_NUM_CH=`DIM, SC_ACC_W=`NUM_BIT, SC_LEN_W.
  - saturating increment/decrement function sat_step(value, dir, en, sat_en) returning the new value and an overflow flag.
- One sub-module, sc_acc_lane: a single-channel accumulator with a clear input, enable, direction and sticky sat flag.
  - The top holds the FSM and bit counter and instantiates NUM_CH lanes in a generate loop.

Test Plan:
- Bipolar, len=8, signs=0, ch0 stream all 1s, ch1 all 0s, ch2 alternating 1,0, ch3 all 1s with sign[3]=1, valid every cycle:
  - required: o_result = {+8, -8, 0, -8}, o_done one cycle, o_sat=0.
- Unipolar, len=5, ch0 bits 1,0,1,1,0 with valid de-asserted 2 cycles mid-stream:
  - required: ch0=+3; o_done delayed by exactly 2 cycles vs the continuous case.
- ACC_W=4, SAT_EN=1, bipolar, len=12, ch0 all 1s, ch1 all 0s:
  - required: ch0=+7, ch1=-8, o_sat[1:0]=2'b11.
  - same test with SAT_EN=0: ch0=+12 mod 16 = -4 (4'b1100), ch1=-12 mod 16 = +4, o_sat=2'b11.
- len=0 start:
  - required: o_done 1 cycle after start, all results 0; i_start during ACC of a len=6 run is ignored, and results match a lone run.
- i_abort after 3 of 8 bits:
  - required: IDLE next cycle, o_res_valid=0, no o_done, partial results held.
  - a following start clears the partial results and o_sat.
- Asynchronous i_rst_udc pulse mid-ACC, between clock edges:
  - required: outputs immediately 0, o_ready=1.
  - next run len=4, all 1s gives +4.
